// File: rtl/jtframe_objscan.sv
// jtframe_objscan: per-line sprite table scanner feeding a 16-px tile drawer.
// Optional per-line tile budget enabled by defining JTFRAME_OBJLIMIT_EN.
module jtframe_objscan #(
  parameter int OBJW  = 8,
  parameter int CODEW = 16,
  parameter int ATTRW = 8,
  parameter int LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             hs,
  input  logic [8:0]       vdump,
  input  logic             rev,
  output logic [OBJW+1:0]  ram_addr,
  input  logic [15:0]      ram_data,
  output logic             dr_start,
  input  logic             dr_busy,
  output logic [CODEW-1:0] dr_code,
  output logic [ATTRW-1:0] dr_attr,
  output logic [8:0]       dr_hpos,
  output logic [3:0]       dr_ysub,
  output logic             dr_hflip,
  output logic             done,
  output logic             miss,
  output logic             ovf
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD0  = 3'd1;
  localparam logic [2:0] RD1  = 3'd2;
  localparam logic [2:0] RD2  = 3'd3;
  localparam logic [2:0] RD3  = 3'd4;
  localparam logic [2:0] CHK  = 3'd5;
  localparam logic [2:0] DRAW = 3'd6;
  localparam logic [2:0] NEXT = 3'd7;

  logic [2:0]       r_st;
  logic [OBJW-1:0]  r_obj;
  logic             r_rev;
  logic             r_hs_d;
  logic [8:0]       r_vdump;
  logic [8:0]       r_y;
  logic [8:0]       r_x;
  logic             r_vf;
  logic             r_hf;
  logic [1:0]       r_vsz;
  logic [1:0]       r_hsz;
  logic [CODEW-1:0] r_w1;
  logic [ATTRW-1:0] r_attr;
  logic [2:0]       r_row;
  logic [3:0]       r_ysub;
  logic [2:0]       r_k;

  logic             w_hs_rise;
  logic [1:0]       w_word;
  logic [8:0]       w_d;
  logic [16:0]      w_prod;
  logic [10:0]      w_yz;
  logic [7:0]       w_vlim;
  logic             w_hit;
  logic [2:0]       w_vmask;
  logic [2:0]       w_hmask;
  logic [2:0]       w_row;
  logic [2:0]       w_col;
  logic [6:0]       w_off;
  logic [OBJW-1:0]  w_last;
  logic             w_issue;

  assign w_hs_rise = hs & ~r_hs_d;
  assign w_word    = (r_st >= RD0 && r_st <= RD3)
                   ? 2'(r_st - RD0) : 2'd0;
  assign ram_addr  = {r_obj, w_word};

  // w3 is consumed straight off the bus during CHK
  assign w_d     = r_vdump - r_y;
  assign w_prod  = 17'(w_d) * 17'(ram_data[7:0]);
  assign w_yz    = w_prod[16:6];
  assign w_vlim  = 8'd16 << r_vsz;
  assign w_hit   = ~w_d[8] && (w_yz < {3'b0, w_vlim});
  assign w_vmask = 3'((4'd1 << r_vsz) - 4'd1);
  assign w_hmask = 3'((4'd1 << r_hsz) - 4'd1);
  assign w_row   = r_vf ? (w_vmask - w_yz[6:4]) : w_yz[6:4];
  assign w_col   = r_hf ? (w_hmask - r_k) : r_k;
  assign w_off   = 7'({4'b0, r_row} << r_hsz) + 7'(w_col);
  assign w_last  = r_rev ? '0 : '1;
  assign w_issue = ~dr_busy & ~dr_start;

`ifdef JTFRAME_OBJLIMIT_EN
  localparam int TCW = $clog2(LIMIT + 1);
  logic [TCW-1:0] r_tiles;
  logic           r_ovf;
  assign ovf = r_ovf;
`else
  // no tile budget: ovf is always 0
  assign ovf = (LIMIT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= IDLE;
      r_obj    <= '0;
      r_rev    <= 1'b0;
      r_hs_d   <= 1'b0;
      r_vdump  <= '0;
      r_y      <= '0;
      r_x      <= '0;
      r_vf     <= 1'b0;
      r_hf     <= 1'b0;
      r_vsz    <= '0;
      r_hsz    <= '0;
      r_w1     <= '0;
      r_attr   <= '0;
      r_row    <= '0;
      r_ysub   <= '0;
      r_k      <= '0;
      dr_start <= 1'b0;
      dr_code  <= '0;
      dr_attr  <= '0;
      dr_hpos  <= '0;
      dr_ysub  <= '0;
      dr_hflip <= 1'b0;
      done     <= 1'b1;
      miss     <= 1'b0;
`ifdef JTFRAME_OBJLIMIT_EN
      r_tiles  <= '0;
      r_ovf    <= 1'b0;
`endif
    end else if (cen) begin
      r_hs_d   <= hs;
      miss     <= 1'b0;
      dr_start <= 1'b0;
      if (w_hs_rise) begin
        miss    <= ~done;
        done    <= 1'b0;
        r_rev   <= rev;
        r_vdump <= vdump;
        r_obj   <= rev ? '1 : '0;
        r_st    <= RD0;
`ifdef JTFRAME_OBJLIMIT_EN
        r_tiles <= '0;
        r_ovf   <= 1'b0;
`endif
      end else begin
        unique case (r_st)
          IDLE: ;
          RD0: r_st <= RD1;
          RD1: begin
            r_vf  <= ram_data[14];
            r_hf  <= ram_data[13];
            r_vsz <= ram_data[12:11];
            r_hsz <= ram_data[10:9];
            r_y   <= ram_data[8:0];
            r_st  <= ram_data[15] ? RD2 : NEXT;
          end
          RD2: begin
            r_w1 <= CODEW'(ram_data);
            r_st <= RD3;
          end
          RD3: begin
            r_x  <= ram_data[8:0];
            r_st <= CHK;
          end
          CHK: begin
            r_attr <= ram_data[8+ATTRW-1:8];
            r_row  <= w_row;
            r_ysub <= w_yz[3:0] ^ {4{r_vf}};
            r_k    <= '0;
            r_st   <= w_hit ? DRAW : NEXT;
          end
          DRAW: begin
            if (w_issue) begin
              dr_start <= 1'b1;
              dr_code  <= r_w1 + CODEW'(w_off);
              dr_attr  <= r_attr;
              dr_hpos  <= r_x + {2'b0, r_k, 4'b0};
              dr_ysub  <= r_ysub;
              dr_hflip <= r_hf;
              r_k      <= r_k + 3'd1;
              if (r_k == w_hmask) r_st <= NEXT;
`ifdef JTFRAME_OBJLIMIT_EN
              r_tiles <= r_tiles + 1'b1;
              if (r_tiles == TCW'(LIMIT - 1)) begin
                r_ovf <= 1'b1;
                done  <= 1'b1;
                r_st  <= IDLE;
              end
`endif
            end
          end
          NEXT: begin
            if (r_obj == w_last) begin
              done <= 1'b1;
              r_st <= IDLE;
            end else begin
              r_obj <= r_rev ? r_obj - 1'b1 : r_obj + 1'b1;
              r_st  <= RD0;
            end
          end
          default: r_st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_objscan.sv
// Directed bench for jtframe_objscan: RAM model, drawer capture, checks.
// Build with JTFRAME_OBJLIMIT_EN to exercise the tile budget (LIMIT=4).
module tb_jtframe_objscan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        hs = 1'b0;
  logic [8:0]  vdump = '0;
  logic        rev = 1'b0;
  logic [9:0]  ram_addr;
  logic [15:0] ram_data;
  logic        dr_start;
  logic        dr_busy = 1'b0;
  logic [15:0] dr_code;
  logic [7:0]  dr_attr;
  logic [8:0]  dr_hpos;
  logic [3:0]  dr_ysub;
  logic        dr_hflip;
  logic        done;
  logic        miss;
  logic        ovf;

  int nchk = 0;
  int nerr = 0;
  int nmiss = 0;

  logic [15:0] mem [0:1023];
  logic [31:0] q_code[$];
  logic [31:0] q_hpos[$];
  logic [31:0] q_ysub[$];
  logic [31:0] q_attr[$];
  logic [31:0] q_hf[$];

  jtframe_objscan #(
    .OBJW(8), .CODEW(16), .ATTRW(8), .LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .hs(hs),
    .vdump(vdump), .rev(rev), .ram_addr(ram_addr),
    .ram_data(ram_data), .dr_start(dr_start),
    .dr_busy(dr_busy), .dr_code(dr_code),
    .dr_attr(dr_attr), .dr_hpos(dr_hpos),
    .dr_ysub(dr_ysub), .dr_hflip(dr_hflip),
    .done(done), .miss(miss), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cen) ram_data <= mem[ram_addr];

  always @(negedge clk) begin
    if (dr_start) begin
      q_code.push_back(32'(dr_code));
      q_hpos.push_back(32'(dr_hpos));
      q_ysub.push_back(32'(dr_ysub));
      q_attr.push_back(32'(dr_attr));
      q_hf.push_back(32'(dr_hflip));
    end
    if (miss) nmiss++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_tab();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
  endtask

  task automatic set_obj(input int o, input logic [15:0] w0,
                         input logic [15:0] w1, input logic [15:0] w2,
                         input logic [15:0] w3);
    mem[o*4]   = w0;
    mem[o*4+1] = w1;
    mem[o*4+2] = w2;
    mem[o*4+3] = w3;
  endtask

  task automatic clr_q();
    q_code.delete(); q_hpos.delete(); q_ysub.delete();
    q_attr.delete(); q_hf.delete();
  endtask

  task automatic do_hs();
    @(negedge clk) hs = 1'b1;
    @(negedge clk) hs = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic scan(input logic [8:0] v, input string tag);
    clr_q();
    vdump = v;
    do_hs();
    wait_done(tag);
  endtask

  initial begin
    clr_tab();
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_start", 32'(dr_start), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_code", 32'(dr_code), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single 16x16 object, 1:1 zoom
    set_obj(0, 16'h8064, 16'h1234, 16'd50, 16'h5A40);
    scan(9'd105, "t1_done");
    chk("t1_n", 32'(q_code.size()), 32'd1);
    chk("t1_code", q_code[0], 32'h1234);
    chk("t1_hpos", q_hpos[0], 32'd50);
    chk("t1_ysub", q_ysub[0], 32'd5);
    chk("t1_attr", q_attr[0], 32'h5A);
    chk("t1_hf", q_hf[0], 32'd0);

    // 4 tiles wide, h-flipped
    set_obj(0, 16'hA464, 16'h1234, 16'd50, 16'h5A40);
    scan(9'd105, "t2_done");
    chk("t2_n", 32'(q_code.size()), 32'd4);
    chk("t2_c0", q_code[0], 32'h1237);
    chk("t2_c1", q_code[1], 32'h1236);
    chk("t2_c2", q_code[2], 32'h1235);
    chk("t2_c3", q_code[3], 32'h1234);
    chk("t2_h0", q_hpos[0], 32'd50);
    chk("t2_h3", q_hpos[3], 32'd98);
    chk("t2_hf", q_hf[2], 32'd1);

    // 2x zoom
    set_obj(0, 16'h8064, 16'h1234, 16'd50, 16'h5A80);
    scan(9'd107, "t3a_done");
    chk("t3a_n", 32'(q_code.size()), 32'd1);
    chk("t3a_ysub", q_ysub[0], 32'd14);
    scan(9'd108, "t3b_done");
    chk("t3b_n", 32'(q_code.size()), 32'd0);
    scan(9'd99, "t3c_done");
    chk("t3c_above", 32'(q_code.size()), 32'd0);

    // zero zoom: one repeated row while d<256
    set_obj(0, 16'h8064, 16'h1234, 16'd50, 16'h5A00);
    scan(9'd300, "t3d_done");
    chk("t3d_n", 32'(q_code.size()), 32'd1);
    chk("t3d_ysub", q_ysub[0], 32'd0);

    // 32-px tall, v-flipped: row 0 maps to row 1
    set_obj(0, 16'hC864, 16'h2000, 16'd50, 16'h0040);
    scan(9'd105, "tvf_done");
    chk("tvf_code", q_code[0], 32'h2001);
    chk("tvf_ysub", q_ysub[0], 32'd10);

    // x wraps across the 9-bit boundary
    set_obj(0, 16'h8264, 16'h0400, 16'h03F8, 16'h0040);
    scan(9'd105, "twr_done");
    chk("twr_h0", q_hpos[0], 32'd504);
    chk("twr_h1", q_hpos[1], 32'd8);

    // drawer busy stalls issue, no tile lost
    set_obj(0, 16'hA464, 16'h1234, 16'd50, 16'h5A40);
    clr_q();
    dr_busy = 1'b1;
    vdump = 9'd105;
    do_hs();
    repeat (20) @(negedge clk);
    chk("t4_stall", 32'(q_code.size()), 32'd0);
    chk("t4_notdone", 32'(done), 32'd0);
    dr_busy = 1'b0;
    wait_done("t4_done");
    chk("t4_n", 32'(q_code.size()), 32'd4);
    chk("t4_c0", q_code[0], 32'h1237);
    chk("t4_c3", q_code[3], 32'h1234);

    // reverse scan order
    set_obj(0, 16'h8064, 16'h1234, 16'd50, 16'h5A40);
    set_obj(255, 16'h8064, 16'h5678, 16'd200, 16'h5A40);
    rev = 1'b1;
    scan(9'd105, "t5_done");
    rev = 1'b0;
    chk("t5_n", 32'(q_code.size()), 32'd2);
    chk("t5_first", q_code[0], 32'h5678);
    chk("t5_hpos", q_hpos[0], 32'd200);
    chk("t5_second", q_code[1], 32'h1234);
    set_obj(255, 16'h0, 16'h0, 16'h0, 16'h0);

    // three 2-tile hits against the tile budget
    set_obj(0, 16'h8264, 16'h0100, 16'd10, 16'h0040);
    set_obj(1, 16'h8264, 16'h0200, 16'd40, 16'h0040);
    set_obj(2, 16'h8264, 16'h0300, 16'd70, 16'h0040);
    scan(9'd105, "t6_done");
    chk("t6_c2", q_code[2], 32'h0200);
`ifdef JTFRAME_OBJLIMIT_EN
    chk("t6_n", 32'(q_code.size()), 32'd4);
    chk("t6_ovf", 32'(ovf), 32'd1);
    do_hs();
    chk("t6_ovfclr", 32'(ovf), 32'd0);
    wait_done("t6_done2");
`else
    chk("t6_n", 32'(q_code.size()), 32'd6);
    chk("t6_c5", q_code[5], 32'h0301);
    chk("t6_ovf", 32'(ovf), 32'd0);
`endif
    chk("t6_nomiss", 32'(nmiss), 32'd0);

    // HS before done: miss, restart at object 0
    clr_tab();
    set_obj(0, 16'h8064, 16'h1234, 16'd50, 16'h5A40);
    clr_q();
    vdump = 9'd105;
    do_hs();
    repeat (40) @(negedge clk);
    chk("t7_busy", 32'(done), 32'd0);
    do_hs();
    chk("t7_miss", 32'(miss), 32'd1);
    chk("t7_addr", 32'(ram_addr), 32'd0);
    wait_done("t7_done");
    chk("t7_n", 32'(q_code.size()), 32'd2);
    chk("t7_nmiss", 32'(nmiss), 32'd1);

    // reset mid-scan
    do_hs();
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t8_done", 32'(done), 32'd1);
    chk("t8_addr", 32'(ram_addr), 32'd0);
    chk("t8_code", 32'(dr_code), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
